// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock frequency meter.
package clk_meas_pkg;

   localparam int CNT_W_DEF = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Increment v (w bits wide, zero-extended) by inc, stopping at all-ones.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic inc,
                                           input int unsigned w);
      logic [63:0] max_v;
      max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (inc && (v != max_v)) ? v + 64'd1 : v;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level and produces rise/fall strobes in the
// destination clock domain. Reusable for any slow asynchronous input.
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/clock_freq_meter.sv
// Measures an asynchronous clock against clock_in: edges per gate window,
// period and high time in clock_in cycles, and a clock-present flag.
module clock_freq_meter
   import clk_meas_pkg::*;
#(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             meas_clk,
   input  logic             enable,
   output logic [CNT_W-1:0] freq_count,
   output logic             count_valid,
   output logic [CNT_W-1:0] period_cycles,
   output logic [CNT_W-1:0] high_cycles,
   output logic             period_valid,
   output logic             clk_present,
   output logic             overflow
);

   localparam int             GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             level, rise, sync_fall_unused;
   logic [GW-1:0]    gate_cnt;
   logic [CNT_W-1:0] edge_cnt, per_cnt, high_cnt;
   logic [CNT_W-1:0] edge_total, per_next, high_next;
   logic             edge_sat, edge_total_sat, per_sat, per_sat_next;
   logic             ovf_win, ovf_per;
   logic             gate_end, arm_hit, capture;
   state_e           state_q, state_d;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clock_in),
      .rst_n (reset_n),
      .din   (meas_clk),
      .level (level),
      .rise  (rise),
      .fall  (sync_fall_unused)
   );

   // Saturating next values; the sat flags remember a clipped count until the result is taken.
   always_comb begin
      gate_end       = enable && (gate_cnt == GATE_LAST);
      edge_total     = CNT_W'(sat_inc(64'(edge_cnt), rise, CNT_W));
      edge_total_sat = edge_sat | (rise & (edge_cnt == CNT_MAX));
      per_next       = CNT_W'(sat_inc(64'(per_cnt), 1'b1, CNT_W));
      high_next      = CNT_W'(sat_inc(64'(high_cnt), level, CNT_W));
      per_sat_next   = per_sat | (per_cnt == CNT_MAX) | (level & (high_cnt == CNT_MAX));
   end

   // Gate window: count rises, publish the total (including a rise on the last cycle).
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         edge_sat    <= 1'b0;
         freq_count  <= '0;
         count_valid <= 1'b0;
         clk_present <= 1'b0;
         ovf_win     <= 1'b0;
      end else if (!enable) begin
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         edge_sat    <= 1'b0;
         count_valid <= 1'b0;
      end else if (gate_end) begin
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         edge_sat    <= 1'b0;
         freq_count  <= edge_total;
         clk_present <= (edge_total != '0);
         ovf_win     <= edge_total_sat;
         count_valid <= 1'b1;
      end else begin
         gate_cnt    <= gate_cnt + GW'(1);
         edge_cnt    <= edge_total;
         edge_sat    <= edge_total_sat;
         count_valid <= 1'b0;
      end
   end

   // Period FSM state register.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Period FSM: wait for a first rise, then capture on every following rise.
   always_comb begin
      state_d = state_q;
      arm_hit = 1'b0;
      capture = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = ARM;
            ARM: if (rise) begin
               state_d = RUN;
               arm_hit = 1'b1;
            end
            RUN: capture = rise;
            default: state_d = IDLE;
         endcase
      end
   end

   // Period/high counters start at 1 on the rise cycle itself (level is high there).
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt       <= '0;
         high_cnt      <= '0;
         per_sat       <= 1'b0;
         period_cycles <= '0;
         high_cycles   <= '0;
         period_valid  <= 1'b0;
         ovf_per       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            per_cnt  <= '0;
            high_cnt <= '0;
            per_sat  <= 1'b0;
         end else if (arm_hit || capture) begin
            if (capture) begin
               period_cycles <= per_cnt;
               high_cycles   <= high_cnt;
               ovf_per       <= per_sat;
               period_valid  <= 1'b1;
            end
            per_cnt  <= CNT_W'(1);
            high_cnt <= CNT_W'(1);
            per_sat  <= 1'b0;
         end else if (state_q == RUN) begin
            per_cnt  <= per_next;
            high_cnt <= high_next;
            per_sat  <= per_sat_next;
         end
      end
   end

   assign overflow = ovf_win | ovf_per;

endmodule
